// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 Booth signed multiplier with overflow flag and one-cycle ready pulse
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] m;
  logic [2*WIDTH:0] p, p_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] ext_u, ext_m, sum;
  logic last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    last = cnt == CW'(WIDTH - 1);
    state_nxt = ctrl_MULT ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    busy = state == RUN;
    data_resultRDY = state == DONE;
  end
  // Upper half is widened by one bit so subtracting the most negative multiplicand cannot wrap
  always_comb begin
    ext_u = {p[2*WIDTH], p[2*WIDTH:WIDTH+1]};
    ext_m = {m[WIDTH-1], m};
    sum = p[1:0] == 2'b01 ? ext_u + ext_m : p[1:0] == 2'b10 ? ext_u - ext_m : ext_u;
    p_nxt = {sum, p[WIDTH:1]};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      m <= '0;
      p <= '0;
      cnt <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      m <= data_operandA;
      p <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      cnt <= '0;
    end else if (state == RUN) begin
      p <= p_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        data_result <= p_nxt[WIDTH:1];
        data_exception <= ~(&p_nxt[2*WIDTH:WIDTH] | ~|p_nxt[2*WIDTH:WIDTH]);
      end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of the Booth multiplier timing, arithmetic, restart and reset behaviour
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic reset, ctrl;
  logic [31:0] a, b, result;
  logic exc, rdy, busy;
  int errors = 0;
  int checks = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ctrl_MULT(ctrl),
    .data_operandA(a), .data_operandB(b),
    .data_result(result), .data_exception(exc),
    .data_resultRDY(rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_mult(input logic [31:0] va, input logic [31:0] vb, input bit garbage,
                         output int lat, output int bc);
    @(negedge clk);
    a = va; b = vb; ctrl = 1'b1;
    @(negedge clk);
    ctrl = 1'b0;
    lat = -1;
    bc = busy ? 1 : 0;
    for (int e = 1; e <= 40 && lat < 0; e++) begin
      if (garbage) begin a = $urandom; b = $urandom; end
      @(negedge clk);
      if (busy) bc++;
      if (rdy) lat = e;
    end
  endtask

  task automatic test_reset;
    int seen;
    reset = 1'b0; ctrl = 1'b0; a = '0; b = '0;
    #3;
    checks++;
    if ({result, exc, rdy, busy} !== 35'd0) begin
      errors++; $display("FAIL reset_asserted: got %h/%b/%b/%b want 0", result, exc, rdy, busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rdy || busy || exc || result != 0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_idle: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_basic;
    int lat, bc;
    do_mult(32'd6, 32'd7, 1'b1, lat, bc);
    checks++;
    if (lat !== 32) begin errors++; $display("FAIL basic_latency: got %0d want 32", lat); end
    checks++;
    if (bc !== 32) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 32", bc); end
    checks++;
    if (result !== 32'd42) begin errors++; $display("FAIL basic_result: got %h want 0000002a", result); end
    checks++;
    if (exc !== 1'b0) begin errors++; $display("FAIL basic_exception: got %b want 0", exc); end
    @(negedge clk);
    checks++;
    if ({rdy, busy} !== 2'b00) begin
      errors++; $display("FAIL basic_pulse_width: got rdy=%b busy=%b want 0 0", rdy, busy);
    end
  endtask

  task automatic test_signed;
    logic [31:0] va[8] = '{32'hFFFFFFFD, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                           32'hFFFFFFFF, 32'h00010000, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] vb[8] = '{32'd5, 32'd2, 32'hFFFFFFFF, 32'd1,
                           32'hFFFFFFFF, 32'h00010000, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] vr[8] = '{32'hFFFFFFF1, 32'hFFFFFFFE, 32'h80000000, 32'h80000000,
                           32'h00000001, 32'h00000000, 32'h00000000, 32'h00000001};
    logic        ve[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int lat, bc;
    for (int i = 0; i < 8; i++) begin
      do_mult(va[i], vb[i], 1'b0, lat, bc);
      checks++;
      if (lat !== 32 || result !== vr[i] || exc !== ve[i]) begin
        errors++;
        $display("FAIL signed_%0d: got lat=%0d res=%h exc=%b want lat=32 res=%h exc=%b",
                 i, lat, result, exc, vr[i], ve[i]);
      end
    end
  endtask

  task automatic test_restart;
    int pulses = 0, redge = -1;
    logic [31:0] r = '0;
    @(negedge clk);
    a = 32'd6; b = 32'd7; ctrl = 1'b1;
    @(negedge clk);
    ctrl = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      @(negedge clk);
      if (rdy) begin pulses++; redge = e; r = result; end
      if (e == 9) begin a = 32'd3; b = 32'd4; ctrl = 1'b1; end
      if (e == 10) ctrl = 1'b0;
    end
    checks++;
    if (pulses !== 1 || redge !== 42) begin
      errors++; $display("FAIL restart_pulse: got %0d pulses at edge %0d want 1 at 42", pulses, redge);
    end
    checks++;
    if (r !== 32'd12) begin errors++; $display("FAIL restart_result: got %h want 0000000c", r); end
  endtask

  task automatic test_held_start;
    int lat = -1;
    @(negedge clk);
    a = 32'd9; b = 32'd9; ctrl = 1'b1;
    @(negedge clk);
    a = 32'd8; b = 32'd8;
    @(negedge clk);
    a = 32'd4; b = 32'd5;
    @(negedge clk);
    ctrl = 1'b0;
    for (int e = 1; e <= 40 && lat < 0; e++) begin
      @(negedge clk);
      if (rdy) lat = e;
    end
    checks++;
    if (lat !== 32 || result !== 32'd20) begin
      errors++; $display("FAIL held_start: got lat=%0d res=%h want lat=32 res=00000014", lat, result);
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int pe[2] = '{-1, -1};
    logic [31:0] pr[2] = '{32'd0, 32'd0};
    @(negedge clk);
    a = 32'd5; b = 32'd6; ctrl = 1'b1;
    @(negedge clk);
    ctrl = 1'b0;
    for (int e = 1; e <= 80; e++) begin
      @(negedge clk);
      ctrl = 1'b0;
      if (rdy) begin
        if (pulses < 2) begin pe[pulses] = e; pr[pulses] = result; end
        pulses++;
        if (pulses == 1) begin a = 32'd9; b = 32'hFFFFFFFE; ctrl = 1'b1; end
      end
    end
    checks++;
    if (pulses !== 2 || pe[0] !== 32 || pe[1] !== 65) begin
      errors++; $display("FAIL b2b_pulses: got %0d at %0d,%0d want 2 at 32,65", pulses, pe[0], pe[1]);
    end
    checks++;
    if (pr[0] !== 32'd30 || pr[1] !== 32'hFFFFFFEE) begin
      errors++; $display("FAIL b2b_results: got %h,%h want 0000001e,ffffffee", pr[0], pr[1]);
    end
  endtask

  task automatic test_async_reset;
    int pulses = 0, lat, bc;
    @(negedge clk);
    a = 32'd6; b = 32'd7; ctrl = 1'b1;
    @(negedge clk);
    ctrl = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({result, exc, rdy, busy} !== 35'd0) begin
      errors++; $display("FAIL async_reset_clear: got %h/%b/%b/%b want 0", result, exc, rdy, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (rdy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL async_reset_no_pulse: got %0d want 0", pulses); end
    do_mult(32'd2, 32'd2, 1'b0, lat, bc);
    checks++;
    if (lat !== 32 || result !== 32'd4) begin
      errors++; $display("FAIL after_reset_mult: got lat=%0d res=%h want lat=32 res=00000004", lat, result);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_restart;
    test_held_start;
    test_back_to_back;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
